// File: rtl/seq_and_tracker.sv
// seq_and_tracker: pipelined hardware monitor for
//   (a ##1 (b, vxa=data, vy=data1) ##GAP c) and (d ##B_DLY (1, vxb=data) ##0 (e==vxb))
//   ##1 (sel_var == data2)
// One attempt may start every cycle. Stage k of the pipeline holds the attempt
// that is k cycles old; all checks for age k are made against the current
// inputs at the edge that ends that cycle.
//
// Valid/ready note: this block has no handshakes. match/fail are single-cycle
// registered pulses; match_val holds the last matching capture.
module seq_and_tracker #(
  parameter int WIDTH        = 8,
  parameter int GAP          = 1,   // >= 1
  parameter int B_DLY        = 1,   // 1 .. GAP+1
  parameter int CHK_SEL      = 0,   // 0: vy, 1: vxa, 2: vxb
  parameter int STRICT_START = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             match,
  output logic [WIDTH-1:0] match_val,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  // Number of pipeline stages: ages 1 .. GAP+2.
  localparam int NS = GAP + 2;
  // Sum width for the failure counter: wide enough for counter + per-cycle failures.
  localparam int SW = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [SW-1:0] SAT = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [NS:1]      valid_q, valid_d;
  logic [WIDTH-1:0] vxa_q [1:NS];
  logic [WIDTH-1:0] vxa_d [1:NS];
  logic [WIDTH-1:0] vy_q  [1:NS];
  logic [WIDTH-1:0] vy_d  [1:NS];
  logic [WIDTH-1:0] vxb_q [1:NS];
  logic [WIDTH-1:0] vxb_d [1:NS];
  logic [2:0]       code_s [1:NS];

  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [2:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] match_val_q, match_val_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic             start;
  logic             strict_fail;
  logic [WIDTH-1:0] sel_var;
  logic             final_ok;
  logic [SW-1:0]    nfail;
  logic [SW-1:0]    fail_sum;

  // Start detection and the optional strict-start failure (age 0).
  always_comb begin
    start       = en & a & d;
    strict_fail = (STRICT_START != 0) & en & (a ^ d);
  end

  // Select which capture of the oldest stage takes part in the final compare.
  always_comb begin
    sel_var = vy_q[NS];
    if (CHK_SEL == 1) sel_var = vxa_q[NS];
    else if (CHK_SEL == 2) sel_var = vxb_q[NS];
    final_ok = (sel_var == data2);
  end

  // Per-stage failure code; later assignments are lower codes so the lowest wins.
  always_comb begin
    for (int k = 1; k <= NS; k++) begin
      code_s[k] = 3'd0;
      if (valid_q[k]) begin
        if (k == NS) begin
          if (!final_ok) code_s[k] = 3'd5;
        end else begin
          if ((k == GAP + 1) && !c)         code_s[k] = 3'd4;
          if ((k == B_DLY) && (e != data))  code_s[k] = 3'd3;
          if ((k == 1) && !b)               code_s[k] = 3'd2;
        end
      end
    end
  end

  // Pipeline advance: survivors shift one stage, captures land in the next stage.
  always_comb begin
    valid_d[1] = start;
    vxa_d[1]   = '0;
    vy_d[1]    = '0;
    vxb_d[1]   = '0;
    for (int k = 2; k <= NS; k++) begin
      valid_d[k] = valid_q[k-1] & (code_s[k-1] == 3'd0);
      vxa_d[k]   = (k - 1 == 1)     ? data  : vxa_q[k-1];
      vy_d[k]    = (k - 1 == 1)     ? data1 : vy_q[k-1];
      vxb_d[k]   = (k - 1 == B_DLY) ? data  : vxb_q[k-1];
    end
  end

  // Result pulses, oldest-failure code and saturating counters.
  always_comb begin
    match_d     = valid_q[NS] & final_ok;
    match_val_d = match_d ? sel_var : match_val_q;
    nfail       = {{(SW-1){1'b0}}, strict_fail};
    fail_code_d = strict_fail ? 3'd1 : 3'd0;
    for (int k = 1; k <= NS; k++) begin
      if (code_s[k] != 3'd0) begin
        nfail       = nfail + {{(SW-1){1'b0}}, 1'b1};
        fail_code_d = code_s[k];
      end
    end
    fail_d   = (fail_code_d != 3'd0);
    fail_sum = {{(SW-CNT_W){1'b0}}, fail_cnt_q} + nfail;

    if (clr) begin
      match_cnt_d = '0;
      fail_cnt_d  = '0;
    end else begin
      match_cnt_d = (match_d && (match_cnt_q != {CNT_W{1'b1}})) ? match_cnt_q + 1'b1
                                                                 : match_cnt_q;
      fail_cnt_d  = (fail_sum > SAT) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= 3'd0;
      match_val_q <= '0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
      for (int k = 1; k <= NS; k++) begin
        vxa_q[k] <= '0;
        vy_q[k]  <= '0;
        vxb_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      match_q     <= match_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
      match_val_q <= match_val_d;
      match_cnt_q <= match_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      for (int k = 1; k <= NS; k++) begin
        vxa_q[k] <= vxa_d[k];
        vy_q[k]  <= vy_d[k];
        vxb_q[k] <= vxb_d[k];
      end
    end
  end

  assign match     = match_q;
  assign match_val = match_val_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign busy      = |valid_q;

endmodule

// File: tb/tb_seq_and_tracker.sv
// Directed bench for seq_and_tracker. Several parameterisations share one
// stimulus bus; each directed step checks the instance it targets.
module tb_seq_and_tracker;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, a, b, c, d;
  logic [7:0] e, data, data1, data2;

  int tests = 0;
  int fails = 0;

  // Default parameters
  logic        m0, f0, bz0;
  logic [7:0]  mv0;
  logic [2:0]  fc0;
  logic [15:0] mc0, fcn0;
  // GAP=2, B_DLY=2, CHK_SEL=2
  logic        m1, f1, bz1;
  logic [7:0]  mv1;
  logic [2:0]  fc1;
  logic [15:0] mc1, fcn1;
  // GAP=2, B_DLY=2, CHK_SEL=0
  logic        m2, f2, bz2;
  logic [7:0]  mv2;
  logic [2:0]  fc2;
  logic [15:0] mc2, fcn2;
  // STRICT_START=1
  logic        m3, f3, bz3;
  logic [7:0]  mv3;
  logic [2:0]  fc3;
  logic [15:0] mc3, fcn3;
  // CNT_W=2
  logic        m4, f4, bz4;
  logic [7:0]  mv4;
  logic [2:0]  fc4;
  logic [1:0]  mc4, fcn4;

  seq_and_tracker u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .e(e), .data(data), .data1(data1), .data2(data2),
    .match(m0), .match_val(mv0), .fail(f0), .fail_code(fc0),
    .match_cnt(mc0), .fail_cnt(fcn0), .busy(bz0));

  seq_and_tracker #(.GAP(2), .B_DLY(2), .CHK_SEL(2)) u_g2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .e(e), .data(data), .data1(data1), .data2(data2),
    .match(m1), .match_val(mv1), .fail(f1), .fail_code(fc1),
    .match_cnt(mc1), .fail_cnt(fcn1), .busy(bz1));

  seq_and_tracker #(.GAP(2), .B_DLY(2), .CHK_SEL(0)) u_g2s0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .e(e), .data(data), .data1(data1), .data2(data2),
    .match(m2), .match_val(mv2), .fail(f2), .fail_code(fc2),
    .match_cnt(mc2), .fail_cnt(fcn2), .busy(bz2));

  seq_and_tracker #(.STRICT_START(1)) u_strict (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .e(e), .data(data), .data1(data1), .data2(data2),
    .match(m3), .match_val(mv3), .fail(f3), .fail_code(fc3),
    .match_cnt(mc3), .fail_cnt(fcn3), .busy(bz3));

  seq_and_tracker #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .e(e), .data(data), .data1(data1), .data2(data2),
    .match(m4), .match_val(mv4), .fail(f4), .fail_code(fc4),
    .match_cnt(mc4), .fail_cnt(fcn4), .busy(bz4));

  // Clock
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
    e = 8'h00; data = 8'h00; data1 = 8'h00; data2 = 8'h00;
  endtask

  // Inputs that satisfy every check of a default-parameter attempt.
  task automatic good_cond();
    b = 1'b1; c = 1'b1; data = 8'h11; data1 = 8'h22; e = 8'h11; data2 = 8'h22;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    chk("rst_match", m0, 0);
    chk("rst_fail", f0, 0);
    chk("rst_code", fc0, 0);
    chk("rst_mval", mv0, 0);
    chk("rst_mcnt", mc0, 0);
    chk("rst_fcnt", fcn0, 0);
    chk("rst_busy", bz0, 0);

    // ---- single clean attempt ----
    a = 1; d = 1;                                   tick();  // c0
    chk("t1_busy", bz0, 1);
    idle(); b = 1; data = 8'h11; data1 = 8'h22; e = 8'h11; tick();  // c1
    chk("t1_fail_c2", f0, 0);
    idle(); c = 1;                                  tick();  // c2
    chk("t1_fail_c3", f0, 0);
    idle(); data2 = 8'h22;                          tick();  // c3
    chk("t1_match", m0, 1);
    chk("t1_mval", mv0, 8'h22);
    chk("t1_mcnt", mc0, 1);
    chk("t1_fail_c4", f0, 0);
    idle();                                         tick();
    chk("t1_match_pulse", m0, 0);
    chk("t1_mval_hold", mv0, 8'h22);

    // ---- e mismatch ----
    do_reset();
    a = 1; d = 1;                                   tick();
    idle(); b = 1; data = 8'h11; data1 = 8'h22; e = 8'h10; tick();
    chk("t2_fail", f0, 1);
    chk("t2_code", fc0, 3);
    chk("t2_fcnt", fcn0, 1);
    idle(); c = 1;                                  tick();
    chk("t2_fail_pulse", f0, 0);
    chk("t2_code_zero", fc0, 0);
    idle(); data2 = 8'h22;                          tick();
    chk("t2_nomatch", m0, 0);
    chk("t2_fcnt_end", fcn0, 1);

    // ---- b low and e mismatch together: lowest code ----
    do_reset();
    a = 1; d = 1;                                   tick();
    idle(); b = 0; data = 8'h11; data1 = 8'h22; e = 8'h10; tick();
    chk("t2b_fail", f0, 1);
    chk("t2b_code", fc0, 2);
    idle(); c = 1;                                  tick();
    idle(); data2 = 8'h22;                          tick();
    chk("t2b_nomatch", m0, 0);
    chk("t2b_fcnt", fcn0, 1);

    // ---- four back-to-back clean attempts ----
    do_reset();
    good_cond(); a = 1; d = 1;
    tick(); tick(); tick(); tick();                          // c0..c3
    chk("t3_m4", m0, 1);
    a = 0; d = 0;
    tick(); chk("t3_m5", m0, 1);
    tick(); chk("t3_m6", m0, 1);
    tick(); chk("t3_m7", m0, 1);
    chk("t3_mcnt", mc0, 4);
    chk("t3_fcnt", fcn0, 0);
    tick(); chk("t3_m8", m0, 0);

    // ---- two failures in one cycle: oldest code reported ----
    do_reset();
    good_cond(); a = 1; d = 1;
    tick(); tick(); tick();                                  // c0..c2
    data2 = 8'h33; b = 0;                           tick();  // c3
    chk("t3b_fail", f0, 1);
    chk("t3b_code", fc0, 5);
    chk("t3b_fcnt", fcn0, 2);
    chk("t3b_nomatch4", m0, 0);
    good_cond(); a = 0; d = 0;                      tick();
    chk("t3b_match5", m0, 1);
    chk("t3b_fail5", f0, 0);
    tick(); chk("t3b_nomatch6", m0, 0);
    tick(); chk("t3b_match7", m0, 1);
    chk("t3b_mcnt", mc0, 2);
    chk("t3b_fcnt_end", fcn0, 2);

    // ---- GAP=2, B_DLY=2, thread-B capture selected / thread-A vy selected ----
    do_reset();
    a = 1; d = 1;                                   tick();  // c0
    idle(); b = 1; data1 = 8'h00;                   tick();  // c1
    chk("t4_busy", bz1, 1);
    idle(); data = 8'h5A; e = 8'h5A;                tick();  // c2
    chk("t4_fail_c3", f1, 0);
    idle(); c = 1;                                  tick();  // c3
    chk("t4_fail_c4", f1, 0);
    idle(); data2 = 8'h5A;                          tick();  // c4
    chk("t4_match", m1, 1);
    chk("t4_mval", mv1, 8'h5A);
    chk("t4_s0_fail", f2, 1);
    chk("t4_s0_code", fc2, 5);
    chk("t4_s0_nomatch", m2, 0);

    // ---- strict start ----
    do_reset();
    a = 1; d = 0;                                   tick();
    chk("t5_strict_fail", f3, 1);
    chk("t5_strict_code", fc3, 1);
    chk("t5_strict_fcnt", fcn3, 1);
    chk("t5_lax_fail", f0, 0);
    chk("t5_lax_busy", bz0, 0);
    idle(); en = 0; a = 1; d = 0;                   tick();
    chk("t5_en0_strict", f3, 0);
    idle(); en = 0; a = 1; d = 1;                   tick();
    chk("t5_en0_busy", bz0, 0);
    chk("t5_en0_fcnt", fcn3, 1);

    // ---- counter saturation with CNT_W=2 ----
    do_reset();
    good_cond(); a = 1; d = 1;
    for (int i = 0; i < 5; i++) tick();
    a = 0; d = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_sat_mcnt", mc4, 3);
    chk("t6_wide_mcnt", mc0, 5);

    // ---- clr with a same-cycle match ----
    a = 1; d = 1;                                   tick();
    a = 0; d = 0;                                   tick();
    tick();
    clr = 1;                                        tick();
    chk("t6_clr_match", m4, 1);
    chk("t6_clr_mcnt", mc4, 0);
    chk("t6_clr_mcnt_def", mc0, 0);
    clr = 0;                                        tick();
    chk("t6_after_clr", mc4, 0);

    // ---- reset in the middle of an attempt ----
    good_cond(); a = 1; d = 1;                      tick();  // c0
    a = 0; d = 0;                                   tick();  // c1
    rst_n = 0;                                      tick();  // c2
    chk("t7_busy", bz0, 0);
    chk("t7_mcnt", mc0, 0);
    chk("t7_fcnt", fcn0, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_nomatch", m0, 0);
      chk("t7_nofail", f0, 0);
    end
    chk("t7_mcnt_end", mc0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_and_tracker.md
Name: seq_and_tracker

Overview:
- Synthesizable RTL monitor for a two-thread sequence "and" with per-thread local-variable capture and a final compare on one selected capture.
- Checks (a ##1 (b, vxa=data, vy=data1) ##GAP c) and (d ##B_DLY (1, vxb=data) ##0 (e==vxb)), then ##1 (sel_var==data2).
- CHK_SEL fixes explicitly which thread's capture is compared, so the check is never ambiguous.
- Pipelined, so one attempt may start every cycle. Sits beside a DUT as a hardware checker, with match/fail pulses and counters.

Parameters:
- WIDTH, 8, width of e, data, data1, data2, match_val.
- GAP, 1, cycles from b to c in thread A (>=1).
- B_DLY, 1, cycles from d to thread-B capture/compare (1..GAP+1).
- CHK_SEL, 0, final compare variable: 0=vy (thread A data1), 1=vxa (thread A data), 2=vxb (thread B data).
- STRICT_START, 0, 1: a xor d sampled high is a failed attempt; 0: such cycles are ignored.
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  start enable; low blocks new attempts, in-flight attempts continue.
- clr  in  1  synchronous counter clear.
- a, b, c, d  in  1 each  sequence terms.
- e  in  WIDTH  thread-B compare operand.
- data, data1, data2  in  WIDTH each  capture/compare data.
- match  out  1  one-cycle pulse, an attempt completed.
- match_val  out  WIDTH  selected capture of the matching attempt; holds last value otherwise.
- fail  out  1  one-cycle pulse, at least one attempt died.
- fail_code  out  3  reason for oldest failing attempt; 0 when fail low.
- match_cnt  out  CNT_W  saturating match count.
- fail_cnt  out  CNT_W  saturating count of failed attempts.
- busy  out  1  any attempt in flight (combinational from valid bits).

Behaviour:
- Reset (rst_n=0 at edge): all attempt slots invalid; match, fail, fail_code, match_val, match_cnt, fail_cnt = 0. Reset mid-attempt discards it silently.
- Attempt start: at an edge with en=1 and a=d=1, age 0.
  - Slots form a shift pipeline of GAP+2 stages, each holding valid, vxa, vy, vxb.
- Age 1:
  - b must be 1.
  - Capture vxa=data and vy=data1.
- Age B_DLY:
  - Capture vxb=data.
  - Require e==data; both happen in the same cycle.
- Ages 2..GAP: thread A is don't-care.
- Age GAP+1:
  - c must be 1.
  - Both threads are complete, so the "and" ends here.
- Age GAP+2: require selected var == data2. Pass gives match.
- Fail codes:
  - 1: strict-start mismatch, sampled at age 0.
  - 2: b low.
  - 3: e mismatch.
  - 4: c low.
  - 5: final compare mismatch.
- Kill rule: an attempt dies at its first failing check and is counted once. If several checks fail in the same cycle for one attempt, report the lowest code.
- Latency: outputs are registered, high in the cycle after the deciding edge. A clean attempt started at edge t gives match at cycle t+GAP+3.
- Simultaneous events:
  - Several attempts failing in one cycle: fail=1, fail_code from the oldest (greatest age); fail_cnt += number failed.
  - Match and fail in the same cycle are both asserted.
  - At most one match per cycle.
- Counters: saturate at all-ones.
  - clr zeroes both counters and has priority over same-cycle increments.
  - clr does not affect attempts or pulses.
- en low: no new starts and no code-1 failures; the pipeline drains normally.

Test Plan:
- Default params. c0 a=d=1; c1 b=1, data=0x11, data1=0x22, e=0x11; c2 c=1; c3 data2=0x22 -> match=1 at c4, match_val=0x22, match_cnt=1, fail never high.
- As above but e=0x10 at c1 -> fail=1, fail_code=3 at c2; no match at c4; fail_cnt=1. With b=0 also at c1 -> single fail, code 2, fail_cnt=1.
- a=d=1 c0..c3, all conditions clean -> match c4..c7, match_cnt=4. Then with c0-attempt data2 wrong at c3 and c2-attempt b=0 at c3 -> fail at c4, code 5, fail_cnt+=2.
- GAP=2, B_DLY=2, CHK_SEL=2, start c0; c2 data=0x5A, e=0x5A; c4 data2=0x5A -> match at c5, match_val=0x5A. With CHK_SEL=0, data1@c1=0x00 -> code 5.
- STRICT_START=1: c0 a=1, d=0 -> fail_code=1 at c1. Same stimulus with STRICT_START=0 or en=0 -> no output.
- CNT_W=2, 5 clean matches -> match_cnt=3. clr with a same-cycle match -> 0. rst_n=0 at c2 of an attempt -> no match/fail afterward, counters 0, busy=0.
